// File: rtl/ldm_stm_sequencer_if.sv
// Bundle between the LDM/STM sequencer and its surroundings: command inputs,
// data-memory port, register-file port and completion status.
// Optional abort input is present only when LDM_STM_ABORT_EN is defined.
interface ldm_stm_sequencer_if #(
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 32
);
  localparam int unsigned RW = $clog2(NREG);

  logic            start;
  logic            is_load;
  logic [AW-1:0]   base_addr;
  logic [NREG-1:0] reg_list;
`ifdef LDM_STM_ABORT_EN
  logic            abort;
`endif
  logic [AW-1:0]   mem_addr;
  logic [AW-1:0]   mem_i;
  logic            mem_en;
  logic            mem_load_en;
  logic            mem_store_en;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [RW-1:0]   reg_rd_addr;
  logic [DW-1:0]   reg_rd_data;
  logic            reg_wr_en;
  logic [RW-1:0]   reg_wr_addr;
  logic [DW-1:0]   reg_wr_data;
  logic            busy;
  logic            done;
  logic [RW:0]     xfer_count;
  logic [AW-1:0]   wb_data;

  // Sequencer side
  modport master (
    input  start, is_load, base_addr, reg_list, mem_rdata, reg_rd_data,
`ifdef LDM_STM_ABORT_EN
    input  abort,
`endif
    output mem_addr, mem_i, mem_en, mem_load_en, mem_store_en, mem_wdata,
    output reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
    output busy, done, xfer_count, wb_data
  );

  // Decode / memory / register-file side
  modport slave (
    output start, is_load, base_addr, reg_list, mem_rdata, reg_rd_data,
`ifdef LDM_STM_ABORT_EN
    output abort,
`endif
    input  mem_addr, mem_i, mem_en, mem_load_en, mem_store_en, mem_wdata,
    input  reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
    input  busy, done, xfer_count, wb_data
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer: one block-transfer command becomes one
// single-word memory access per listed register, lowest register first.
// Access outputs are decoded from the current state so each listed register
// costs exactly one cycle. Define LDM_STM_ABORT_EN to add the abort input.
module ldm_stm_sequencer #(
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 8
) (
  input logic                 clk,
  input logic                 rst,
  ldm_stm_sequencer_if.master bus
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned CW = RW + 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            load_q, load_d;
  logic [AW-1:0]   base_q, base_d;
  logic [NREG-1:0] list_q, list_d;
  logic [CW-1:0]   count_q, count_d;
  logic [RW-1:0]   cur_reg;
  logic            abort_c;

`ifdef LDM_STM_ABORT_EN
  assign abort_c = bus.abort;
`else
  assign abort_c = 1'b0;
`endif

  // State and latched command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      base_q  <= '0;
      list_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      base_q  <= base_d;
      list_q  <= list_d;
      count_q <= count_d;
    end
  end

  // Lowest set bit of the remaining register list
  always_comb begin
    cur_reg = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (list_q[i]) cur_reg = RW'(i);
    end
  end

  // Next state, latched-command updates and decoded outputs
  always_comb begin
    state_d          = state_q;
    load_d           = load_q;
    base_d           = base_q;
    list_d           = list_q;
    count_d          = count_q;
    bus.mem_addr     = '0;
    bus.mem_i        = '0;
    bus.mem_en       = 1'b0;
    bus.mem_load_en  = 1'b0;
    bus.mem_store_en = 1'b0;
    bus.mem_wdata    = '0;
    bus.reg_rd_addr  = '0;
    bus.reg_wr_en    = 1'b0;
    bus.reg_wr_addr  = '0;
    bus.reg_wr_data  = '0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.xfer_count   = '0;
    bus.wb_data      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_d  = bus.is_load;
          base_d  = bus.base_addr;
          list_d  = bus.reg_list;
          count_d = '0;
          state_d = (bus.reg_list == '0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        bus.busy = 1'b1;
        if (abort_c) begin
          state_d = S_DONE;
        end else begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q;
          bus.mem_i    = AW'(count_q);
          if (load_q) begin
            bus.mem_load_en = 1'b1;
            bus.reg_wr_en   = 1'b1;
            bus.reg_wr_addr = cur_reg;
            bus.reg_wr_data = bus.mem_rdata;
          end else begin
            bus.mem_store_en = 1'b1;
            bus.reg_rd_addr  = cur_reg;
            bus.mem_wdata    = bus.reg_rd_data;
          end
          list_d  = list_q & (list_q - NREG'(1));
          count_d = count_q + CW'(1);
          if ((list_q & (list_q - NREG'(1))) == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.busy       = 1'b1;
        bus.done       = 1'b1;
        bus.xfer_count = count_q;
        bus.wb_data    = base_q + AW'(count_q);
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: randomized and directed block transfers checked
// every cycle against a transfer-list model, with a 16-word memory and a
// 16-entry register file kept beside the DUT.
module tb_ldm_stm_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ldm_stm_sequencer_if bus ();
  ldm_stm_sequencer dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct {
    int          kind;   // 1 access, 2 aborted cycle, 3 done
    logic        ld;
    logic [3:0]  r;
    logic [7:0]  i;
    logic [7:0]  base;
    logic [31:0] data;
    logic [4:0]  cnt;
    logic [7:0]  wb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mmem[16];
  logic [31:0] mreg[16];
  logic [31:0] mem_env[16];
  logic [31:0] reg_env[16];
  logic        sync_env = 1'b0;
  logic [3:0]  env_idx;
  logic [4:0]  last_cnt;
  logic [7:0]  last_wb;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory and register file seen by the DUT
  assign env_idx         = bus.mem_addr[3:0] + bus.mem_i[3:0];
  assign bus.mem_rdata   = mem_env[env_idx];
  assign bus.reg_rd_data = reg_env[bus.reg_rd_addr];

  always @(posedge clk) begin
    if (sync_env) begin
      mem_env <= mmem;
      reg_env <= mreg;
    end else begin
      if (bus.mem_en && bus.mem_store_en) mem_env[env_idx] <= bus.mem_wdata;
      if (bus.reg_wr_en) reg_env[bus.reg_wr_addr] <= bus.reg_wr_data;
    end
  end

  // Per-cycle compare against the expected transfer stream
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("rst_zero", 32'(|{bus.mem_addr, bus.mem_i, bus.mem_en, bus.mem_load_en,
          bus.mem_store_en, bus.mem_wdata, bus.reg_rd_addr, bus.reg_wr_en, bus.reg_wr_addr,
          bus.reg_wr_data, bus.busy, bus.done, bus.xfer_count, bus.wb_data}), 32'd0);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.kind == 1) begin
        chk("mem_en", 32'(bus.mem_en), 32'd1);
        chk("busy", 32'(bus.busy), 32'd1);
        chk("done", 32'(bus.done), 32'd0);
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.base));
        chk("mem_i", 32'(bus.mem_i), 32'(e.i));
        chk("load_en", 32'(bus.mem_load_en), 32'(e.ld));
        chk("store_en", 32'(bus.mem_store_en), 32'(!e.ld));
        chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(e.ld));
        if (e.ld) begin
          chk("reg_wr_addr", 32'(bus.reg_wr_addr), 32'(e.r));
          chk("reg_wr_data", bus.reg_wr_data, e.data);
        end else begin
          chk("reg_rd_addr", 32'(bus.reg_rd_addr), 32'(e.r));
          chk("mem_wdata", bus.mem_wdata, e.data);
        end
      end else if (e.kind == 2) begin
        chk("abort_quiet", 32'({bus.mem_en, bus.mem_load_en, bus.mem_store_en, bus.reg_wr_en}), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
      end else begin
        last_cnt = bus.xfer_count;
        last_wb  = bus.wb_data;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_mem_en", 32'({bus.mem_en, bus.reg_wr_en}), 32'd0);
        chk("xfer_count", 32'(bus.xfer_count), 32'(e.cnt));
        chk("wb_data", 32'(bus.wb_data), 32'(e.wb));
      end
    end else begin
      chk("idle", 32'({bus.busy, bus.done, bus.mem_en, bus.reg_wr_en}), 32'd0);
    end
    if (rst) begin
      chk("ld_st_excl", 32'(bus.mem_load_en && bus.mem_store_en), 32'd0);
      chk("wr_needs_ld", 32'(bus.reg_wr_en && !bus.mem_load_en), 32'd0);
    end
  end

  // Expected stream for one command; applies the model writes of the kept accesses
  task automatic build(input logic ld, input logic [7:0] base, input logic [15:0] list,
                       input int keep, input int tail);
    exp_t e;
    exp_t recs[$];
    int n = 0;
    logic [3:0] a;
    for (int r = 0; r < 16; r++) begin
      if (list[r]) begin
        a      = base[3:0] + 4'(n);
        e.kind = 1; e.ld = ld; e.r = 4'(r); e.i = 8'(n); e.base = base;
        e.data = ld ? mmem[a] : mreg[r];
        e.cnt  = '0; e.wb = '0;
        recs.push_back(e);
        n++;
      end
    end
    for (int k = 0; k < keep; k++) begin
      exp_q.push_back(recs[k]);
      a = base[3:0] + recs[k].i[3:0];
      if (recs[k].ld) mreg[recs[k].r] = recs[k].data;
      else mmem[a] = recs[k].data;
    end
    if (tail == 2) begin e.kind = 2; exp_q.push_back(e); end
    if (tail != 0) begin
      e.kind = 3; e.cnt = 5'(keep); e.wb = base + 8'(keep);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_sync();
    @(negedge clk); #2 sync_env = 1'b1;
    @(negedge clk); #2 sync_env = 1'b0;
  endtask

  task automatic drive_start(input logic ld, input logic [7:0] base, input logic [15:0] list);
    bus.start = 1'b1; bus.is_load = ld; bus.base_addr = base; bus.reg_list = list;
  endtask

  task automatic drain_and_check();
    int w = 0;
    int dm = 0;
    int dr = 0;
    while (exp_q.size() != 0 && w < 60) begin @(negedge clk); w++; end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk); #2;
    for (int a = 0; a < 16; a++) begin
      if (mem_env[a] !== mmem[a]) dm++;
      if (reg_env[a] !== mreg[a]) dr++;
    end
    chk("mem_image", 32'(dm), 32'd0);
    chk("reg_image", 32'(dr), 32'd0);
  endtask

  // poke: 0 none, 1 extra start during accesses, 2 extra start in the done cycle
  task automatic run_cmd(input logic ld, input logic [7:0] base, input logic [15:0] list, input int poke);
    int n = $countones(list);
    @(negedge clk); #2;
    drive_start(ld, base, list);
    build(ld, base, list, n, 1);
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk); #2;
      bus.start = 1'b0;
      if ((poke == 1 && (c == 3 || c == 4) && c <= n - 1) || (poke == 2 && c == n + 1))
        drive_start(1'($urandom), 8'($urandom), 16'($urandom) | 16'h0001);
    end
    drain_and_check();
  endtask

  task automatic randomize_model();
    for (int a = 0; a < 16; a++) begin mmem[a] = $urandom; mreg[a] = $urandom; end
    do_sync();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] lst;
    bus.start = 1'b0; bus.is_load = 1'b0; bus.base_addr = '0; bus.reg_list = '0;
`ifdef LDM_STM_ABORT_EN
    bus.abort = 1'b0;
`endif
    for (int a = 0; a < 16; a++) begin mmem[a] = 32'h0; mreg[a] = 32'h0; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    randomize_model();

    // STM of r0, r2 to base 3
    mreg[0] = 32'hAAAA_0001; mreg[2] = 32'hBBBB_0002;
    do_sync();
    run_cmd(1'b0, 8'd3, 16'h0005, 2);
    chk("t1_mem3", mem_env[3], 32'hAAAA_0001);
    chk("t1_mem4", mem_env[4], 32'hBBBB_0002);
    chk("t1_cnt", 32'(last_cnt), 32'd2);
    chk("t1_wb", 32'(last_wb), 32'd5);

    // LDM into r0, r15 from base 0
    mmem[0] = 32'd11; mmem[1] = 32'd22;
    do_sync();
    run_cmd(1'b1, 8'd0, 16'h8001, 0);
    chk("t2_r0", reg_env[0], 32'd11);
    chk("t2_r15", reg_env[15], 32'd22);
    chk("t2_cnt", 32'(last_cnt), 32'd2);

    // Empty list
    run_cmd(1'b0, 8'h7E, 16'h0000, 0);
    chk("t3_cnt", 32'(last_cnt), 32'd0);
    chk("t3_wb", 32'(last_wb), 32'h7E);

    // Full list with ignored start pulses, wb wraps
    run_cmd(1'b0, 8'hF8, 16'hFFFF, 1);
    chk("t4_cnt", 32'(last_cnt), 32'd16);
    chk("t4_wb", 32'(last_wb), 32'h08);

    // Reset during the third access of a five-register LDM
    randomize_model();
    @(negedge clk); #2;
    drive_start(1'b1, 8'h22, 16'h0853);
    build(1'b1, 8'h22, 16'h0853, 2, 0);
    @(negedge clk); #2 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("t5_busy", 32'({bus.busy, bus.mem_en, bus.reg_wr_en, bus.done}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    drain_and_check();
    run_cmd(1'b1, 8'h22, 16'h0853, 0);
    chk("t5_cnt", 32'(last_cnt), 32'd5);

`ifdef LDM_STM_ABORT_EN
    // Abort on the second access of a four-register STM
    @(negedge clk); #2;
    drive_start(1'b0, 8'h40, 16'h00F0);
    build(1'b0, 8'h40, 16'h00F0, 1, 2);
    @(negedge clk); #2 bus.start = 1'b0;
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    drain_and_check();
    chk("t6_cnt", 32'(last_cnt), 32'd1);
`endif

    // Randomized commands
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) randomize_model();
      case ($urandom_range(0, 3))
        0:       lst = 16'h0000;
        1:       lst = 16'($urandom & $urandom & $urandom);
        2:       lst = 16'($urandom);
        default: lst = 16'hFFFF;
      endcase
      run_cmd(1'($urandom), 8'($urandom), lst, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
